multi_edge_detector: RTL and testbench

Parametrised multi-channel successor to the single-bit edge detector. Each channel passes through a synchroniser and a debounce/glitch filter, then produces:
- a filtered level;
- one-cycle rise and fall pulses;
- per-channel enable-qualified event pulses;
- sticky event flags with write-1-clear.

A shared saturating event counter and an interrupt line sit on top. Used at GPIO/button/external-strobe boundaries feeding control FSMs and interrupt logic.

---
 rtl/multi_edge_detector.sv | 124 ++++++++++++
 tb/tb_multi_edge_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector.
// Each channel runs a raw input through a synchroniser and a debounce filter.
// The filtered level produces one-cycle rise and fall pulses.
// Those pulses, gated by per-channel enables, form event pulses.
// Events set sticky flags and add into a shared saturating counter.
module multi_edge_detector #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] r_edge,
    output logic [WIDTH-1:0] f_edge,
    output logic [WIDTH-1:0] evt,
    output logic [WIDTH-1:0] evt_flag,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             irq
);

    localparam int FC_W  = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + PC_W;

    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_CYCLES - 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [FC_W-1:0]  fc [WIDTH];
    logic [PC_W-1:0]  evt_pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [SUM_W-1:0] pop_ext;
    logic [CNT_W-1:0] cnt_next;

    // Synchroniser chain; the last stage is the filter's view of the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce filter: Q follows s only after FILT_CYCLES consecutive
    // differing cycles. Edge pulses fire on the cycle Q changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q      <= '0;
            r_edge <= '0;
            f_edge <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                fc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_edge[i] <= 1'b0;
                f_edge[i] <= 1'b0;
                if (s[i] == Q[i]) begin
                    fc[i] <= '0;
                end else if (fc[i] == FC_LAST) begin
                    Q[i]      <= s[i];
                    fc[i]     <= '0;
                    r_edge[i] <= s[i];
                    f_edge[i] <= ~s[i];
                end else begin
                    fc[i] <= fc[i] + FC_W'(1);
                end
            end
        end
    end

    // Enable-qualified events and their population count.
    always_comb begin
        evt     = (r_edge & rise_en) | (f_edge & fall_en);
        evt_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt_pop = evt_pop + PC_W'(evt[i]);
        end
    end

    // Saturating next count. A clear reloads with this cycle's events so
    // that coincident events are not lost.
    always_comb begin
        pop_ext  = SUM_W'(evt_pop);
        cnt_sum  = SUM_W'(evt_cnt) + pop_ext;
        cnt_next = '1;
        if (cnt_clr) begin
            if (pop_ext <= CNT_MAX) begin
                cnt_next = pop_ext[CNT_W-1:0];
            end
        end else if (cnt_sum <= CNT_MAX) begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    // Sticky flags (set beats clear) and the aggregate counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_flag <= '0;
            evt_cnt  <= '0;
        end else begin
            evt_flag <= (evt_flag & ~clr) | evt;
            evt_cnt  <= cnt_next;
        end
    end

    assign irq = |evt_flag;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector.
// Two instances share one stimulus: the default configuration and a 3-bit
// counter variant, so counter saturation is exercised on the same run.
module tb_multi_edge_detector;
    localparam int W = 4;
    localparam int S = 2;
    localparam int F = 4;
    localparam int HL = S + F;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] in, rise_en, fall_en, clr;
    logic         cnt_clr;

    logic [W-1:0] q_a, r_a, f_a, evt_a, flag_a;
    logic [7:0]   cnt_a;
    logic         irq_a;
    logic [W-1:0] q_b, r_b, f_b, evt_b, flag_b;
    logic [2:0]   cnt_b;
    logic         irq_b;

    multi_edge_detector dut_a (
        .clk(clk), .rst(rst), .in(in), .rise_en(rise_en), .fall_en(fall_en),
        .clr(clr), .cnt_clr(cnt_clr), .Q(q_a), .r_edge(r_a), .f_edge(f_a),
        .evt(evt_a), .evt_flag(flag_a), .evt_cnt(cnt_a), .irq(irq_a)
    );

    multi_edge_detector #(.CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in(in), .rise_en(rise_en), .fall_en(fall_en),
        .clr(clr), .cnt_clr(cnt_clr), .Q(q_b), .r_edge(r_b), .f_edge(f_b),
        .evt(evt_b), .evt_flag(flag_b), .evt_cnt(cnt_b), .irq(irq_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel's level flips once the last F synchroniser outputs all
    // disagree with it. hist[ch][0] is the newest sampled input; the filter
    // sees the sample taken S edges earlier.
    bit        hist [W][HL];
    logic [W-1:0] mq, mr, mf, mflag;
    int        mc8, mc3;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < W; c++)
                for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
            mq = '0; mr = '0; mf = '0; mflag = '0; mc8 = 0; mc3 = 0;
        end else begin
            logic [W-1:0] ev;
            int pc;
            ev = (mr & rise_en) | (mf & fall_en);
            pc = $countones(ev);
            mflag = (mflag & ~clr) | ev;
            mc8 = cnt_clr ? pc : ((mc8 + pc > 255) ? 255 : mc8 + pc);
            mc3 = cnt_clr ? ((pc > 7) ? 7 : pc) : ((mc3 + pc > 7) ? 7 : mc3 + pc);
            for (int c = 0; c < W; c++) begin
                bit all_diff;
                for (int k = HL - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = in[c];
                all_diff = 1'b1;
                for (int k = S; k < HL; k++)
                    if (hist[c][k] == mq[c]) all_diff = 1'b0;
                if (all_diff) begin
                    mq[c] = ~mq[c];
                    mr[c] = mq[c];
                    mf[c] = ~mq[c];
                end else begin
                    mr[c] = 1'b0;
                    mf[c] = 1'b0;
                end
            end
        end
    end

    // Scoreboard: compare both instances against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            logic [W-1:0] exp_evt;
            exp_evt = (mr & rise_en) | (mf & fall_en);
            check("a.Q", 32'(q_a), 32'(mq));
            check("a.r_edge", 32'(r_a), 32'(mr));
            check("a.f_edge", 32'(f_a), 32'(mf));
            check("a.evt", 32'(evt_a), 32'(exp_evt));
            check("a.evt_flag", 32'(flag_a), 32'(mflag));
            check("a.irq", 32'(irq_a), 32'(|mflag));
            check("a.evt_cnt", 32'(cnt_a), 32'(mc8));
            check("b.Q", 32'(q_b), 32'(mq));
            check("b.evt_flag", 32'(flag_b), 32'(mflag));
            check("b.evt_cnt", 32'(cnt_b), 32'(mc3));
        end
    end

    // driver
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst = 1'b1; in = '0; rise_en = 4'hF; fall_en = '0; clr = '0; cnt_clr = 1'b0;
        @(posedge clk); #2;
        started = 1;
        step(1);
        check("reset Q", 32'(q_a), 32'h0);
        check("reset cnt", 32'(cnt_a), 32'h0);
        check("reset irq", 32'(irq_a), 32'h0);
        rst = 1'b0;

        // 1: basic rise with six-edge latency
        in[0] = 1'b1;
        step(5);
        check("t1 Q0 before edge 6", 32'(q_a[0]), 32'h0);
        step(1);
        check("t1 Q0 at edge 6", 32'(q_a[0]), 32'h1);
        check("t1 r_edge0", 32'(r_a[0]), 32'h1);
        step(1);
        check("t1 r_edge0 one cycle", 32'(r_a[0]), 32'h0);
        check("t1 evt_flag", 32'(flag_a), 32'h1);
        check("t1 irq", 32'(irq_a), 32'h1);
        check("t1 evt_cnt", 32'(cnt_a), 32'h1);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        in[1] = 1'b1; step(3); in[1] = 1'b0; step(10);
        check("t2 glitch Q1", 32'(q_a[1]), 32'h0);
        in[1] = 1'b1; step(4); in[1] = 1'b0;
        step(1);
        check("t2 r_edge1 early", 32'(r_a[1]), 32'h0);
        step(1);
        check("t2 r_edge1", 32'(r_a[1]), 32'h1);
        step(3);
        check("t2 f_edge1 early", 32'(f_a[1]), 32'h0);
        step(1);
        check("t2 f_edge1", 32'(f_a[1]), 32'h1);
        check("t2 Q1 low", 32'(q_a[1]), 32'h0);
        step(5);

        // 3: enables gate events only
        clr = 4'hF; cnt_clr = 1'b1; step(1); clr = '0; cnt_clr = 1'b0;
        check("t3 flags cleared", 32'(flag_a), 32'h0);
        rise_en = '0; fall_en = 4'h4;
        in[2] = 1'b1; step(10); in[2] = 1'b0; step(10);
        check("t3 evt_cnt", 32'(cnt_a), 32'h1);
        check("t3 evt_flag", 32'(flag_a), 32'h4);

        // 4: set beats clear
        rise_en = 4'h4;
        in[2] = 1'b1; step(6);
        check("t4 evt2", 32'(evt_a[2]), 32'h1);
        clr = 4'h4; step(1);
        check("t4 flag2 kept", 32'(flag_a[2]), 32'h1);
        step(1);
        check("t4 flag2 cleared", 32'(flag_a[2]), 32'h0);
        check("t4 irq", 32'(irq_a), 32'h0);
        clr = '0;

        // 5: counter saturation and clear-with-events
        rise_en = 4'hF; fall_en = 4'hF;
        in = '0; step(10);
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        check("t5 cnt cleared", 32'(cnt_b), 32'h0);
        in = 4'hF; step(10);
        check("t5 cnt3 four", 32'(cnt_b), 32'h4);
        check("t5 cnt8 four", 32'(cnt_a), 32'h4);
        in = 4'h0; step(10);
        check("t5 cnt3 saturated", 32'(cnt_b), 32'h7);
        check("t5 cnt8 eight", 32'(cnt_a), 32'h8);
        in = 4'hF; step(6);
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        check("t5 cnt3 clr+evt", 32'(cnt_b), 32'h4);
        check("t5 cnt8 clr+evt", 32'(cnt_a), 32'h4);
        step(4);

        // 6: reset with a partial filter count
        in[3] = 1'b0; step(4);
        rst = 1'b1; step(1);
        check("t6 Q", 32'(q_a), 32'h0);
        check("t6 r_edge", 32'(r_a), 32'h0);
        check("t6 f_edge", 32'(f_a), 32'h0);
        check("t6 flags", 32'(flag_a), 32'h0);
        check("t6 cnt", 32'(cnt_a), 32'h0);
        check("t6 irq", 32'(irq_a), 32'h0);
        rst = 1'b0;
        step(5);
        check("t6 Q before latency", 32'(q_a), 32'h0);
        step(1);
        check("t6 Q after latency", 32'(q_a), 32'h7);
        check("t6 r_edge after latency", 32'(r_a), 32'h7);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
